controlador_de_jogo: RTL and testbench
======================================

// Module: controlador_de_jogo
// PURPOSE
//  Central game sequencer for the battleship board. Replaces the purely combinational
//  status decode with a registered FSM: off -> map preparation -> attack -> victory/defeat.
//  Issues single-cycle strobes to seletor_mapa (load map) and gerenciador_de_ataque
//  (register shot). Owns lives/hit counters and enables for matriz_leds and display.
// PARAMETERS
//  VIDA_INICIAL    7    lives loaded on entry to DESLIGADO (1..7)
//  CELULAS_NAVIO   9    ship cells in a map; hits needed to win (1..35)
//  TIMEOUT_AVAL    15   clock cycles to wait for an attack result (1..255)
//  PISCA_TICKS     4    tick_lento pulses per blink half-period in VITORIA (1..15)
// PORTS
//  clock            in   1  system clock (divided clock_out[15] domain)
//  reset            in   1  asynchronous, active-high
//  modo             in   2  {ch7,ch6}: 00 off, 01 preparacao, 10 ataque, 11 off (invalid)
//  confirmar        in   1  one-cycle pulse from level_to_pulse (btn0)
//  tick_lento       in   1  one-cycle enable for blink timing
//  res_valido       in   1  attack result strobe from gerenciador_de_ataque
//  res_acerto       in   1  qualifies res_valido: shot hit a ship cell
//  res_repetido     in   1  qualifies res_valido: cell already attacked (overrides acerto)
//  carregar_mapa    out  1  one-cycle strobe: latch selected map
//  registrar_ataque out  1  one-cycle strobe: apply current coordinates
//  en_preparacao    out  1  high in PREPARACAO
//  en_ataque        out  1  high in ATAQUE and AVALIA
//  ligar_matriz     out  1  LED matrix enable
//  vida             out  3  remaining lives
//  acertos          out  6  hits so far
//  estado           out  3  state code for display/status LEDs
//  erro_mapa        out  1  high while modo=10 requested without a loaded map
// BEHAVIOUR
//  Reset: state DESLIGADO; vida=VIDA_INICIAL; acertos=0; mapa_ok=0; all strobes and
//  enables 0; blink counter 0, phase 1. All outputs registered; strobes last exactly 1 cycle.
//  Global rule: modo in {00,11} in any state -> DESLIGADO next cycle. It outranks
//  confirmar and res_valido in the same cycle.
//  DESLIGADO: vida<=VIDA_INICIAL, acertos<=0, mapa_ok<=0. modo=01 -> PREPARACAO.
//    modo=10 -> stay; erro_mapa=1.
//  PREPARACAO: en_preparacao=1, ligar_matriz=1. confirmar -> carregar_mapa next cycle,
//    mapa_ok<=1. Repeated confirms reload the map. modo=10 & mapa_ok -> ATAQUE.
//    modo=10 & !mapa_ok -> stay; erro_mapa=1.
//  ATAQUE: ligar_matriz=1. confirmar -> registrar_ataque next cycle, go AVALIA, clear timer.
//    modo=01 is ignored: no return to preparation mid-game.
//  AVALIA: confirmar is ignored. Timer counts cycles. On res_valido:
//    repetido -> ATAQUE, no counter change.
//    acerto -> acertos+1; if the new value equals CELULAS_NAVIO -> VITORIA, else ATAQUE.
//    miss -> vida-1; if the new value is 0 -> DERROTA, else ATAQUE.
//    Timer reaches TIMEOUT_AVAL without res_valido -> ATAQUE, no change.
//  VITORIA: ligar_matriz = blink phase, toggled every PISCA_TICKS tick_lento pulses.
//  DERROTA: ligar_matriz=0.
//  Exit from VITORIA/DERROTA only via modo off.
//  Counters saturate: vida never underflows below 0; acertos never exceeds CELULAS_NAVIO.
//  estado: 0 DESLIGADO, 1 PREPARACAO, 2 ATAQUE, 3 AVALIA, 4 VITORIA, 5 DERROTA.
//  Reset asserted mid-game returns to reset values asynchronously; any pending strobe is dropped.
// STRUCTURE
//  Shared include jogo_defs.vh: state codes (ST_*), modo codes, default VIDA/CELULAS constants.
//  Reused by display and status LED logic.
//  One sub-module: temporizador_pisca (tick_lento prescaler, PISCA_TICKS -> phase toggle,
//  cleared when not in VITORIA). The FSM, counters and timeout stay in this module.
// TESTING
//  Reset, modo=10, confirmar -> stays DESLIGADO; erro_mapa=1; no strobes.
//  modo=01, confirmar, modo=10 -> exactly one carregar_mapa pulse; estado 1 then 2.
//  In ATAQUE: confirmar then res_valido with acerto=0, seven times -> vida 7..0,
//    estado=5, ligar_matriz=0.
//  CELULAS_NAVIO=2: two hits -> estado=4; ligar_matriz toggles every 4 tick_lento pulses.
//  confirmar, no result for 15 cycles -> back to estado=2; vida and acertos unchanged.
//  res_repetido=1 with acerto=1 -> no count.
//  In AVALIA, modo=00 in the same cycle as res_valido -> DESLIGADO; vida reloaded to 7.

Source files
------------

// File: rtl/controlador_de_jogo_pkg.sv
// Shared definitions for the battleship game sequencer: state codes, modo
// switch codes and default game constants, also used by the display and
// status LED logic.
package controlador_de_jogo_pkg;

  typedef enum logic [2:0] {
    ST_DESLIGADO  = 3'd0,
    ST_PREPARACAO = 3'd1,
    ST_ATAQUE     = 3'd2,
    ST_AVALIA     = 3'd3,
    ST_VITORIA    = 3'd4,
    ST_DERROTA    = 3'd5
  } estado_t;

  localparam logic [1:0] MODO_DESLIGADO  = 2'b00;
  localparam logic [1:0] MODO_PREPARACAO = 2'b01;
  localparam logic [1:0] MODO_ATAQUE     = 2'b10;
  localparam logic [1:0] MODO_INVALIDO   = 2'b11;

  localparam int VIDA_PADRAO    = 7;
  localparam int CELULAS_PADRAO = 9;
  localparam int TIMEOUT_PADRAO = 15;
  localparam int PISCA_PADRAO   = 4;

  // The invalid switch combination is treated exactly like "off".
  function automatic logic modo_desligado(input logic [1:0] modo);
    return (modo == MODO_DESLIGADO) || (modo == MODO_INVALIDO);
  endfunction

endpackage

// File: rtl/controlador_de_jogo_if.sv
// Signal bundle between the game sequencer and the rest of the board:
// switches/buttons and attack results in, strobes/enables/status out.
interface controlador_de_jogo_if;

  logic [1:0] modo;
  logic       confirmar;
  logic       tick_lento;
  logic       res_valido;
  logic       res_acerto;
  logic       res_repetido;

  logic       carregar_mapa;
  logic       registrar_ataque;
  logic       en_preparacao;
  logic       en_ataque;
  logic       ligar_matriz;
  logic [2:0] vida;
  logic [5:0] acertos;
  logic [2:0] estado;
  logic       erro_mapa;

  // Board side: drives the controls, observes the sequencer.
  modport master (
    output modo, confirmar, tick_lento, res_valido, res_acerto, res_repetido,
    input  carregar_mapa, registrar_ataque, en_preparacao, en_ataque,
    input  ligar_matriz, vida, acertos, estado, erro_mapa
  );

  // Sequencer side.
  modport slave (
    input  modo, confirmar, tick_lento, res_valido, res_acerto, res_repetido,
    output carregar_mapa, registrar_ataque, en_preparacao, en_ataque,
    output ligar_matriz, vida, acertos, estado, erro_mapa
  );

endinterface

// File: rtl/controlador_de_jogo_temporizador_pisca.sv
// Blink timer for the victory display: counts tick_lento pulses and toggles
// the blink phase every PISCA_TICKS pulses. Held cleared (count 0, phase 1)
// whenever it is not enabled, so every victory starts with the matrix lit.
module temporizador_pisca #(
  parameter int PISCA_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic habilitar,
  input  logic tick,
  output logic fase_prox
);

  localparam logic [3:0] CNT_FIM = 4'(PISCA_TICKS - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       fase_q, fase_d;

  // Next count/phase; exposed so the owner can register it in step with its FSM.
  always_comb begin
    cnt_d  = cnt_q;
    fase_d = fase_q;
    if (!habilitar) begin
      cnt_d  = 4'd0;
      fase_d = 1'b1;
    end else if (tick) begin
      if (cnt_q == CNT_FIM) begin
        cnt_d  = 4'd0;
        fase_d = ~fase_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Prescaler and phase registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= 4'd0;
      fase_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      fase_q <= fase_d;
    end
  end

  assign fase_prox = fase_d;

endmodule

// File: rtl/controlador_de_jogo.sv
// Central battleship game sequencer: off -> map preparation -> attack ->
// evaluation -> victory/defeat. Owns the lives and hit counters, the attack
// result timeout, and issues one-cycle strobes to the map selector and the
// attack manager. Every output comes straight from a register.
module controlador_de_jogo
  import controlador_de_jogo_pkg::*;
#(
  parameter int VIDA_INICIAL  = VIDA_PADRAO,
  parameter int CELULAS_NAVIO = CELULAS_PADRAO,
  parameter int TIMEOUT_AVAL  = TIMEOUT_PADRAO,
  parameter int PISCA_TICKS   = PISCA_PADRAO
) (
  input  logic                  clock,
  input  logic                  reset,
  controlador_de_jogo_if.slave  bus
);

  localparam logic [2:0] VIDA_RST  = 3'(VIDA_INICIAL);
  localparam logic [5:0] CEL_MAX   = 6'(CELULAS_NAVIO);
  localparam logic [7:0] TIMER_FIM = 8'(TIMEOUT_AVAL - 1);

  estado_t    estado_q, estado_d;
  logic [2:0] vida_q, vida_d;
  logic [5:0] acertos_q, acertos_d;
  logic       mapa_ok_q, mapa_ok_d;
  logic [7:0] timer_q, timer_d;

  logic       carregar_q, carregar_d;
  logic       registrar_q, registrar_d;
  logic       erro_q, erro_d;
  logic       en_prep_q, en_prep_d;
  logic       en_atq_q, en_atq_d;
  logic       ligar_q, ligar_d;

  logic       desligar;
  logic       fase_prox;

  // Hit count stops at the number of ship cells.
  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v >= CEL_MAX) ? CEL_MAX : v + 6'd1;
  endfunction

  // Lives stop at zero.
  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  assign desligar = modo_desligado(bus.modo);

  temporizador_pisca #(
    .PISCA_TICKS (PISCA_TICKS)
  ) u_pisca (
    .clock     (clock),
    .reset     (reset),
    .habilitar (estado_q == ST_VITORIA),
    .tick      (bus.tick_lento),
    .fase_prox (fase_prox)
  );

  // Next-state, counter and strobe decode; switching off outranks everything.
  always_comb begin
    estado_d    = estado_q;
    vida_d      = vida_q;
    acertos_d   = acertos_q;
    mapa_ok_d   = mapa_ok_q;
    timer_d     = timer_q;
    carregar_d  = 1'b0;
    registrar_d = 1'b0;
    erro_d      = 1'b0;

    if (desligar) begin
      estado_d = ST_DESLIGADO;
    end else begin
      unique case (estado_q)
        ST_DESLIGADO: begin
          if (bus.modo == MODO_PREPARACAO) estado_d = ST_PREPARACAO;
          else                             erro_d   = 1'b1;
        end
        ST_PREPARACAO: begin
          if (bus.confirmar) begin
            carregar_d = 1'b1;
            mapa_ok_d  = 1'b1;
          end
          if (bus.modo == MODO_ATAQUE) begin
            if (mapa_ok_q) estado_d = ST_ATAQUE;
            else           erro_d   = 1'b1;
          end
        end
        ST_ATAQUE: begin
          // Going back to preparation mid-game is deliberately not possible.
          if (bus.confirmar) begin
            registrar_d = 1'b1;
            estado_d    = ST_AVALIA;
            timer_d     = 8'd0;
          end
        end
        ST_AVALIA: begin
          if (bus.res_valido) begin
            if (bus.res_repetido) begin
              estado_d = ST_ATAQUE;
            end else if (bus.res_acerto) begin
              acertos_d = sat_inc(acertos_q);
              estado_d  = (acertos_d == CEL_MAX) ? ST_VITORIA : ST_ATAQUE;
            end else begin
              vida_d   = sat_dec(vida_q);
              estado_d = (vida_d == 3'd0) ? ST_DERROTA : ST_ATAQUE;
            end
          end else if (timer_q == TIMER_FIM) begin
            estado_d = ST_ATAQUE;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        ST_VITORIA, ST_DERROTA: begin
          estado_d = estado_q;
        end
        default: estado_d = ST_DESLIGADO;
      endcase
    end

    // Being (or landing) in DESLIGADO always reloads a fresh game.
    if (estado_d == ST_DESLIGADO) begin
      vida_d    = VIDA_RST;
      acertos_d = 6'd0;
      mapa_ok_d = 1'b0;
    end
  end

  // Enables follow the next state so they line up with the registered state code.
  always_comb begin
    en_prep_d = (estado_d == ST_PREPARACAO);
    en_atq_d  = (estado_d == ST_ATAQUE) || (estado_d == ST_AVALIA);
    unique case (estado_d)
      ST_PREPARACAO, ST_ATAQUE, ST_AVALIA: ligar_d = 1'b1;
      ST_VITORIA:                          ligar_d = fase_prox;
      default:                             ligar_d = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= ST_DESLIGADO;
      vida_q      <= VIDA_RST;
      acertos_q   <= 6'd0;
      mapa_ok_q   <= 1'b0;
      timer_q     <= 8'd0;
      carregar_q  <= 1'b0;
      registrar_q <= 1'b0;
      erro_q      <= 1'b0;
      en_prep_q   <= 1'b0;
      en_atq_q    <= 1'b0;
      ligar_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      vida_q      <= vida_d;
      acertos_q   <= acertos_d;
      mapa_ok_q   <= mapa_ok_d;
      timer_q     <= timer_d;
      carregar_q  <= carregar_d;
      registrar_q <= registrar_d;
      erro_q      <= erro_d;
      en_prep_q   <= en_prep_d;
      en_atq_q    <= en_atq_d;
      ligar_q     <= ligar_d;
    end
  end

  assign bus.estado           = estado_q;
  assign bus.vida             = vida_q;
  assign bus.acertos          = acertos_q;
  assign bus.carregar_mapa    = carregar_q;
  assign bus.registrar_ataque = registrar_q;
  assign bus.erro_mapa        = erro_q;
  assign bus.en_preparacao    = en_prep_q;
  assign bus.en_ataque        = en_atq_q;
  assign bus.ligar_matriz     = ligar_q;

endmodule

// File: tb/tb_controlador_de_jogo.sv
// Bench for the game sequencer: per-cycle stimulus with expected outputs
// queued at drive time and checked one edge later.
module tb_controlador_de_jogo;

  logic clk;
  logic rst;

  controlador_de_jogo_if bus ();

  controlador_de_jogo #(
    .VIDA_INICIAL  (7),
    .CELULAS_NAVIO (2),
    .TIMEOUT_AVAL  (15),
    .PISCA_TICKS   (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] modo;
    logic       conf;
    logic       tick;
    logic       rv;
    logic       ac;
    logic       rp;
    logic [2:0] est;
    logic [2:0] vida;
    logic [5:0] acertos;
    logic       carr;
    logic       regi;
    logic       ligar;
    logic       erro;
  } vetor_t;

  vetor_t fila[$];
  vetor_t tabela[7];
  int     n_cmp = 0;
  int     n_err = 0;

  function automatic vetor_t mk(
    input logic [1:0] modo, input logic conf, input logic tick,
    input logic rv, input logic ac, input logic rp,
    input logic [2:0] est, input logic [2:0] vida, input logic [5:0] acertos,
    input logic carr, input logic regi, input logic ligar, input logic erro);
    vetor_t v;
    v.modo = modo; v.conf = conf; v.tick = tick; v.rv = rv; v.ac = ac; v.rp = rp;
    v.est = est; v.vida = vida; v.acertos = acertos;
    v.carr = carr; v.regi = regi; v.ligar = ligar; v.erro = erro;
    return v;
  endfunction

  task automatic chk(input string nome, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nome, $time, act, exp);
    end
  endtask

  task automatic verifica(input vetor_t e);
    chk("estado",           8'(bus.estado),           8'(e.est));
    chk("vida",             8'(bus.vida),             8'(e.vida));
    chk("acertos",          8'(bus.acertos),          8'(e.acertos));
    chk("carregar_mapa",    8'(bus.carregar_mapa),    8'(e.carr));
    chk("registrar_ataque", 8'(bus.registrar_ataque), 8'(e.regi));
    chk("ligar_matriz",     8'(bus.ligar_matriz),     8'(e.ligar));
    chk("erro_mapa",        8'(bus.erro_mapa),        8'(e.erro));
    chk("en_preparacao",    8'(bus.en_preparacao),    8'(e.est == 3'd1));
    chk("en_ataque",        8'(bus.en_ataque),        8'((e.est == 3'd2) || (e.est == 3'd3)));
  endtask

  task automatic aplica(input vetor_t v);
    bus.modo         = v.modo;
    bus.confirmar    = v.conf;
    bus.tick_lento   = v.tick;
    bus.res_valido   = v.rv;
    bus.res_acerto   = v.ac;
    bus.res_repetido = v.rp;
  endtask

  // One clock: drive, queue the expectation, sample after the edge.
  task automatic passo(input vetor_t v);
    aplica(v);
    fila.push_back(v);
    @(posedge clk);
    #1;
    verifica(fila.pop_front());
  endtask

  initial begin
    // Opening sequence: map errors, map load, attack entry, modo=01 ignored.
    tabela[0] = mk(2'b10, 1, 0, 0, 0, 0, 3'd0, 3'd7, 6'd0, 0, 0, 0, 1);
    tabela[1] = mk(2'b10, 0, 0, 0, 0, 0, 3'd0, 3'd7, 6'd0, 0, 0, 0, 1);
    tabela[2] = mk(2'b01, 0, 0, 0, 0, 0, 3'd1, 3'd7, 6'd0, 0, 0, 1, 0);
    tabela[3] = mk(2'b01, 1, 0, 0, 0, 0, 3'd1, 3'd7, 6'd0, 1, 0, 1, 0);
    tabela[4] = mk(2'b01, 0, 0, 0, 0, 0, 3'd1, 3'd7, 6'd0, 0, 0, 1, 0);
    tabela[5] = mk(2'b10, 0, 0, 0, 0, 0, 3'd2, 3'd7, 6'd0, 0, 0, 1, 0);
    tabela[6] = mk(2'b01, 0, 0, 0, 0, 0, 3'd2, 3'd7, 6'd0, 0, 0, 1, 0);

    rst = 1'b1;
    aplica(mk(2'b00, 0, 0, 0, 0, 0, 3'd0, 3'd7, 6'd0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    fila.push_back(mk(2'b00, 0, 0, 0, 0, 0, 3'd0, 3'd7, 6'd0, 0, 0, 0, 0));
    verifica(fila.pop_front());
    rst = 1'b0;

    for (int i = 0; i < 7; i++) passo(tabela[i]);

    // Seven misses: lives 7 down to 0, then defeat with the matrix dark.
    for (int i = 0; i < 7; i++) begin
      passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd3, 3'(7 - i), 6'd0, 0, 1, 1, 0));
      passo(mk(2'b10, 0, 0, 1, 0, 0, (i == 6) ? 3'd5 : 3'd2, 3'(6 - i), 6'd0,
               0, 0, (i == 6) ? 1'b0 : 1'b1, 0));
    end
    passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd5, 3'd0, 6'd0, 0, 0, 0, 0));
    passo(mk(2'b00, 0, 0, 0, 0, 0, 3'd0, 3'd7, 6'd0, 0, 0, 0, 0));

    // Second game: map flag was cleared by switching off.
    passo(mk(2'b01, 0, 0, 0, 0, 0, 3'd1, 3'd7, 6'd0, 0, 0, 1, 0));
    passo(mk(2'b10, 0, 0, 0, 0, 0, 3'd1, 3'd7, 6'd0, 0, 0, 1, 1));
    passo(mk(2'b01, 1, 0, 0, 0, 0, 3'd1, 3'd7, 6'd0, 1, 0, 1, 0));
    passo(mk(2'b10, 0, 0, 0, 0, 0, 3'd2, 3'd7, 6'd0, 0, 0, 1, 0));

    // Timeout: 15 cycles in evaluation without a result, nothing counted.
    passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd3, 3'd7, 6'd0, 0, 1, 1, 0));
    for (int k = 0; k < 14; k++)
      passo(mk(2'b10, (k == 3), 0, 0, 0, 0, 3'd3, 3'd7, 6'd0, 0, 0, 1, 0));
    passo(mk(2'b10, 0, 0, 0, 0, 0, 3'd2, 3'd7, 6'd0, 0, 0, 1, 0));

    // Repeated cell overrides a hit.
    passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd3, 3'd7, 6'd0, 0, 1, 1, 0));
    passo(mk(2'b10, 0, 0, 1, 1, 1, 3'd2, 3'd7, 6'd0, 0, 0, 1, 0));
    // Hit, miss, hit: second hit wins with two ship cells.
    passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd3, 3'd7, 6'd0, 0, 1, 1, 0));
    passo(mk(2'b10, 0, 0, 1, 1, 0, 3'd2, 3'd7, 6'd1, 0, 0, 1, 0));
    passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd3, 3'd7, 6'd1, 0, 1, 1, 0));
    passo(mk(2'b10, 0, 0, 1, 0, 0, 3'd2, 3'd6, 6'd1, 0, 0, 1, 0));
    passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd3, 3'd6, 6'd1, 0, 1, 1, 0));
    passo(mk(2'b10, 0, 0, 1, 1, 0, 3'd4, 3'd6, 6'd2, 0, 0, 1, 0));

    // Victory blink: phase flips on every 4th tick_lento pulse.
    for (int k = 0; k < 4; k++)
      passo(mk(2'b10, 0, 1, 0, 0, 0, 3'd4, 3'd6, 6'd2, 0, 0, (k != 3), 0));
    passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd4, 3'd6, 6'd2, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      passo(mk(2'b10, 0, 1, 0, 0, 0, 3'd4, 3'd6, 6'd2, 0, 0, (k == 3), 0));
    passo(mk(2'b00, 0, 0, 0, 0, 0, 3'd0, 3'd7, 6'd0, 0, 0, 0, 0));

    // Third game: switching off in the same cycle as a miss result.
    passo(mk(2'b01, 0, 0, 0, 0, 0, 3'd1, 3'd7, 6'd0, 0, 0, 1, 0));
    passo(mk(2'b01, 1, 0, 0, 0, 0, 3'd1, 3'd7, 6'd0, 1, 0, 1, 0));
    passo(mk(2'b10, 0, 0, 0, 0, 0, 3'd2, 3'd7, 6'd0, 0, 0, 1, 0));
    passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd3, 3'd7, 6'd0, 0, 1, 1, 0));
    passo(mk(2'b10, 0, 0, 1, 0, 0, 3'd2, 3'd6, 6'd0, 0, 0, 1, 0));
    passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd3, 3'd6, 6'd0, 0, 1, 1, 0));
    passo(mk(2'b00, 0, 0, 1, 0, 0, 3'd0, 3'd7, 6'd0, 0, 0, 0, 0));

    // Fourth game: asynchronous reset drops the pending attack strobe.
    passo(mk(2'b01, 0, 0, 0, 0, 0, 3'd1, 3'd7, 6'd0, 0, 0, 1, 0));
    passo(mk(2'b01, 1, 0, 0, 0, 0, 3'd1, 3'd7, 6'd0, 1, 0, 1, 0));
    passo(mk(2'b10, 0, 0, 1, 0, 0, 3'd2, 3'd7, 6'd0, 0, 0, 1, 0));
    passo(mk(2'b10, 0, 0, 0, 0, 0, 3'd2, 3'd7, 6'd0, 0, 0, 1, 0));
    passo(mk(2'b10, 1, 0, 0, 0, 0, 3'd3, 3'd7, 6'd0, 0, 1, 1, 0));
    rst = 1'b1;
    #1;
    fila.push_back(mk(2'b10, 0, 0, 0, 0, 0, 3'd0, 3'd7, 6'd0, 0, 0, 0, 0));
    verifica(fila.pop_front());
    #2;
    rst = 1'b0;
    // Map flag is gone after reset, so attack mode is refused.
    passo(mk(2'b10, 0, 0, 0, 0, 0, 3'd0, 3'd7, 6'd0, 0, 0, 0, 1));
    passo(mk(2'b00, 0, 0, 0, 0, 0, 3'd0, 3'd7, 6'd0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
